// File: rtl/mult_control.sv
// Sequencing FSM for the 8-bit add-shift signed multiplier.
// Steps the X:A:B register datapath through one clear, then N_BITS
// evaluate/shift pairs, then holds Done until Run is released.
module mult_control #(
  parameter int N_BITS = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Run,
  input  logic ClearA_LoadB,
  input  logic Mval,
  output logic Load_B,
  output logic Clr_XA,
  output logic Yes_Add,
  output logic Yes_Sub,
  output logic Shift_En,
  output logic Busy,
  output logic Done
);

  localparam int CW = $clog2(N_BITS) + 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL,
    SHIFT,
    DONE
  } state_t;

  state_t state;
  state_t state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // State and iteration counter register with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter update; ClearA_LoadB outranks Run while idle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      IDLE: begin
        if (!ClearA_LoadB && Run) begin
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        cnt_next   = '0;
        state_next = EVAL;
      end
      EVAL: begin
        state_next = SHIFT;
      end
      SHIFT: begin
        cnt_next = cnt + 1'b1;
        if (cnt == LAST) begin
          state_next = DONE;
        end else begin
          state_next = EVAL;
        end
      end
      DONE: begin
        if (!Run) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output decode: mostly Moore, with IDLE load/clear and EVAL add/sub gated by inputs
  always_comb begin
    Load_B   = 1'b0;
    Clr_XA   = 1'b0;
    Yes_Add  = 1'b0;
    Yes_Sub  = 1'b0;
    Shift_En = 1'b0;
    Busy     = 1'b0;
    Done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (ClearA_LoadB) begin
          Load_B = 1'b1;
          Clr_XA = 1'b1;
        end
      end
      CLEAR: begin
        Clr_XA = 1'b1;
        Busy   = 1'b1;
      end
      EVAL: begin
        Busy = 1'b1;
        if (Mval) begin
          if (cnt == LAST) begin
            Yes_Sub = 1'b1;
          end else begin
            Yes_Add = 1'b1;
          end
        end
      end
      SHIFT: begin
        Busy     = 1'b1;
        Shift_En = 1'b1;
      end
      DONE: begin
        Done = 1'b1;
      end
      default: begin
        Busy = 1'b0;
      end
    endcase
  end

endmodule
